apb_master_bridge: RTL and testbench



---
 rtl/apb_master_bridge_if.sv | 49 ++++
 rtl/apb_master_bridge.sv | 188 ++++++++++++++++++
 tb/tb_apb_master_bridge.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_bridge_if.sv
// Command/response stream and APB bus bundle for apb_master_bridge.
// The master modport is the bridge's view; the slave modport is the view of
// whatever sits on the far side (command source, response sink and APB slave).
interface apb_master_bridge_if #(
   parameter int BUS_WIDTH  = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int STRB_WIDTH = 4
);
   // command stream
   logic                  cmd_valid_i;
   logic                  cmd_ready_o;
   logic                  cmd_write_i;
   logic [ADDR_WIDTH-1:0] cmd_addr_i;
   logic [BUS_WIDTH-1:0]  cmd_wdata_i;
   logic [STRB_WIDTH-1:0] cmd_strb_i;
   // response stream
   logic                  rsp_valid_o;
   logic [BUS_WIDTH-1:0]  rsp_rdata_o;
   logic                  rsp_slverr_o;
   logic                  rsp_timeout_o;
   // APB
   logic                  psel_o;
   logic                  penable_o;
   logic                  pwrite_o;
   logic [ADDR_WIDTH-1:0] paddr_o;
   logic [BUS_WIDTH-1:0]  pwdata_o;
   logic [STRB_WIDTH-1:0] pstrb_o;
   logic [BUS_WIDTH-1:0]  prdata_i;
   logic                  pready_i;
   logic                  pslverr_i;
   // accelerator status
   logic                  busy_i;

   modport master (
      input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
      output cmd_ready_o,
      output rsp_valid_o, rsp_rdata_o, rsp_slverr_o, rsp_timeout_o,
      output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o,
      input  prdata_i, pready_i, pslverr_i, busy_i
   );

   modport slave (
      output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
      input  cmd_ready_o,
      input  rsp_valid_o, rsp_rdata_o, rsp_slverr_o, rsp_timeout_o,
      input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o,
      output prdata_i, pready_i, pslverr_i, busy_i
   );
endinterface

// File: rtl/apb_master_bridge.sv
// APB initiator: turns each accepted valid/ready command into one APB
// transfer (SETUP then ACCESS) and returns a single-cycle response pulse.
// Optional feature macro APB_MASTER_TIMEOUT_EN: aborts an ACCESS phase that
// sees no pready_i for TIMEOUT_CYCLES cycles and reports slverr + timeout.
// All APB and response outputs come straight from flops.
module apb_master_bridge #(
   parameter int BUS_WIDTH      = 32,
   parameter int ADDR_WIDTH     = 16,
   parameter int STRB_WIDTH     = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   apb_master_bridge_if.master  bus
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;

   if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
      $error("apb_master_bridge: TIMEOUT_CYCLES must be at least 2");
   end

   logic [1:0]            state_r, state_s;
   logic                  cmd_ready_r, cmd_ready_s;
   logic                  psel_r, psel_s;
   logic                  penable_r, penable_s;
   logic                  pwrite_r, pwrite_s;
   logic [ADDR_WIDTH-1:0] paddr_r, paddr_s;
   logic [BUS_WIDTH-1:0]  pwdata_r, pwdata_s;
   logic [STRB_WIDTH-1:0] pstrb_r, pstrb_s;
   logic                  rsp_valid_r, rsp_valid_s;
   logic [BUS_WIDTH-1:0]  rsp_rdata_r, rsp_rdata_s;
   logic                  rsp_slverr_r, rsp_slverr_s;

   // busy_i is status only; software reads it over APB, the FSM ignores it
   logic unused_busy_s;
   assign unused_busy_s = bus.busy_i;

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
   logic [CNT_W-1:0] wait_cnt_r, wait_cnt_s;
   logic             rsp_timeout_r, rsp_timeout_s;
`endif

   // next-state and next-output decode for the IDLE/SETUP/ACCESS sequence
   always_comb begin
      state_s      = state_r;
      cmd_ready_s  = cmd_ready_r;
      psel_s       = psel_r;
      penable_s    = penable_r;
      pwrite_s     = pwrite_r;
      paddr_s      = paddr_r;
      pwdata_s     = pwdata_r;
      pstrb_s      = pstrb_r;
      rsp_valid_s  = 1'b0;
      rsp_rdata_s  = rsp_rdata_r;
      rsp_slverr_s = rsp_slverr_r;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_s    = wait_cnt_r;
      rsp_timeout_s = rsp_timeout_r;
`endif
      case (state_r)
         ST_IDLE: begin
            if (bus.cmd_valid_i && cmd_ready_r) begin
               // the address/data flops double as the command latch
               state_s     = ST_SETUP;
               cmd_ready_s = 1'b0;
               psel_s      = 1'b1;
               penable_s   = 1'b0;
               pwrite_s    = bus.cmd_write_i;
               paddr_s     = bus.cmd_addr_i;
               pwdata_s    = bus.cmd_write_i ? bus.cmd_wdata_i : {BUS_WIDTH{1'b0}};
               pstrb_s     = bus.cmd_write_i ? bus.cmd_strb_i : {STRB_WIDTH{1'b0}};
            end else begin
               cmd_ready_s = 1'b1;
               psel_s      = 1'b0;
               penable_s   = 1'b0;
            end
         end
         ST_SETUP: begin
            state_s   = ST_ACCESS;
            penable_s = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt_s = {CNT_W{1'b0}};
`endif
         end
         ST_ACCESS: begin
            if (bus.pready_i) begin
               // normal completion also wins over a timeout on the same cycle
               state_s      = ST_IDLE;
               cmd_ready_s  = 1'b1;
               psel_s       = 1'b0;
               penable_s    = 1'b0;
               rsp_valid_s  = 1'b1;
               rsp_rdata_s  = pwrite_r ? {BUS_WIDTH{1'b0}} : bus.prdata_i;
               rsp_slverr_s = bus.pslverr_i;
`ifdef APB_MASTER_TIMEOUT_EN
               rsp_timeout_s = 1'b0;
`endif
            end else begin
`ifdef APB_MASTER_TIMEOUT_EN
               if (wait_cnt_r == CNT_LAST) begin
                  state_s       = ST_IDLE;
                  cmd_ready_s   = 1'b1;
                  psel_s        = 1'b0;
                  penable_s     = 1'b0;
                  rsp_valid_s   = 1'b1;
                  rsp_rdata_s   = {BUS_WIDTH{1'b0}};
                  rsp_slverr_s  = 1'b1;
                  rsp_timeout_s = 1'b1;
               end else begin
                  wait_cnt_s = wait_cnt_r + CNT_ONE;
               end
`else
               state_s = ST_ACCESS;
`endif
            end
         end
         default: begin
            state_s     = ST_IDLE;
            cmd_ready_s = 1'b1;
            psel_s      = 1'b0;
            penable_s   = 1'b0;
         end
      endcase
   end

   // state and output registers; reset drops the bus and discards any command
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r      <= ST_IDLE;
         cmd_ready_r  <= 1'b1;
         psel_r       <= 1'b0;
         penable_r    <= 1'b0;
         pwrite_r     <= 1'b0;
         paddr_r      <= {ADDR_WIDTH{1'b0}};
         pwdata_r     <= {BUS_WIDTH{1'b0}};
         pstrb_r      <= {STRB_WIDTH{1'b0}};
         rsp_valid_r  <= 1'b0;
         rsp_rdata_r  <= {BUS_WIDTH{1'b0}};
         rsp_slverr_r <= 1'b0;
      end else begin
         state_r      <= state_s;
         cmd_ready_r  <= cmd_ready_s;
         psel_r       <= psel_s;
         penable_r    <= penable_s;
         pwrite_r     <= pwrite_s;
         paddr_r      <= paddr_s;
         pwdata_r     <= pwdata_s;
         pstrb_r      <= pstrb_s;
         rsp_valid_r  <= rsp_valid_s;
         rsp_rdata_r  <= rsp_rdata_s;
         rsp_slverr_r <= rsp_slverr_s;
      end
   end

`ifdef APB_MASTER_TIMEOUT_EN
   // ACCESS wait counter and timeout flag
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wait_cnt_r    <= {CNT_W{1'b0}};
         rsp_timeout_r <= 1'b0;
      end else begin
         wait_cnt_r    <= wait_cnt_s;
         rsp_timeout_r <= rsp_timeout_s;
      end
   end
   assign bus.rsp_timeout_o = rsp_timeout_r;
`else
   assign bus.rsp_timeout_o = 1'b0;
`endif

   assign bus.cmd_ready_o  = cmd_ready_r;
   assign bus.psel_o       = psel_r;
   assign bus.penable_o    = penable_r;
   assign bus.pwrite_o     = pwrite_r;
   assign bus.paddr_o      = paddr_r;
   assign bus.pwdata_o     = pwdata_r;
   assign bus.pstrb_o      = pstrb_r;
   assign bus.rsp_valid_o  = rsp_valid_r;
   assign bus.rsp_rdata_o  = rsp_rdata_r;
   assign bus.rsp_slverr_o = rsp_slverr_r;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: a vector table of APB transfers,
// a response scoreboard, and hand-written back-to-back, timeout and reset cases.
module tb_apb_master_bridge;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   apb_master_bridge_if #(.BUS_WIDTH(32), .ADDR_WIDTH(16), .STRB_WIDTH(4)) bus ();

   apb_master_bridge #(
      .BUS_WIDTH(32), .ADDR_WIDTH(16), .STRB_WIDTH(4), .TIMEOUT_CYCLES(8)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic        write;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          waits;
      logic [31:0] prdata;
      logic        pslverr;
      logic [31:0] exp_rdata;
      logic        exp_slverr;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        slverr;
      logic        timeout;
   } rsp_t;

   rsp_t sb_q[$];
   int   chk_cnt  = 0;
   int   pass_cnt = 0;
   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // scoreboard: every response pulse must match the oldest outstanding expectation
   always @(negedge clk) begin : monitor
      rsp_t e;
      if (bus.rsp_valid_o === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response at %0t", $time);
         end else begin
            e = sb_q.pop_front();
            check("rsp_rdata", bus.rsp_rdata_o, e.rdata);
            check("rsp_slverr", {31'd0, bus.rsp_slverr_o}, {31'd0, e.slverr});
            check("rsp_timeout", {31'd0, bus.rsp_timeout_o}, {31'd0, e.timeout});
         end
      end
   end

   task automatic present(input vec_t v, input rsp_t e);
      bus.cmd_valid_i = 1'b1;
      bus.cmd_write_i = v.write;
      bus.cmd_addr_i  = v.addr;
      bus.cmd_wdata_i = v.wdata;
      bus.cmd_strb_i  = v.strb;
      sb_q.push_back(e);
   endtask

   // caller sits at a negedge; returns just after the accepting posedge
   task automatic wait_accept(output int n);
      n = 0;
      while (bus.cmd_ready_o !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("accept_bound", {31'd0, (n < 20)}, 32'd1);
      @(posedge clk);
      #1;
      bus.cmd_valid_i = 1'b0;
   endtask

   // walks SETUP and ACCESS checking the bus, ends at the response negedge
   task automatic xfer_body(input vec_t v);
      logic [31:0] exp_wd;
      logic [3:0]  exp_st;
      exp_wd = v.write ? v.wdata : 32'd0;
      exp_st = v.write ? v.strb : 4'd0;
      @(negedge clk);
      check("setup_psel", {31'd0, bus.psel_o}, 32'd1);
      check("setup_penable", {31'd0, bus.penable_o}, 32'd0);
      check("setup_ready", {31'd0, bus.cmd_ready_o}, 32'd0);
      check("setup_paddr", {16'd0, bus.paddr_o}, {16'd0, v.addr});
      check("setup_pwrite", {31'd0, bus.pwrite_o}, {31'd0, v.write});
      check("setup_pwdata", bus.pwdata_o, exp_wd);
      check("setup_pstrb", {28'd0, bus.pstrb_o}, {28'd0, exp_st});
      bus.pready_i  = 1'b1;
      bus.pslverr_i = 1'b1;
      bus.prdata_i  = 32'hDEAD_0BAD;
      for (int i = 0; i <= v.waits; i++) begin
         @(negedge clk);
         check("access_sel_en", {30'd0, bus.psel_o, bus.penable_o}, 32'd3);
         check("access_paddr", {16'd0, bus.paddr_o}, {16'd0, v.addr});
         check("access_pwdata", bus.pwdata_o, exp_wd);
         check("access_pstrb", {28'd0, bus.pstrb_o}, {28'd0, exp_st});
         if (i == v.waits) begin
            bus.pready_i  = 1'b1;
            bus.prdata_i  = v.prdata;
            bus.pslverr_i = v.pslverr;
         end else begin
            bus.pready_i  = 1'b0;
            bus.prdata_i  = 32'hBAD0_0000 + 32'(i);
            bus.pslverr_i = 1'b1;
         end
      end
      @(negedge clk);
      bus.pready_i  = 1'b0;
      bus.pslverr_i = 1'b0;
      bus.prdata_i  = 32'h0BAD_F00D;
      check("rsp_pulse", {31'd0, bus.rsp_valid_o}, 32'd1);
      check("rsp_bus_idle", {30'd0, bus.psel_o, bus.penable_o}, 32'd0);
      check("rsp_ready", {31'd0, bus.cmd_ready_o}, 32'd1);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no finish within 200000 ns expected completion");
      $fatal(1);
   end

   initial begin : stim
      int   n;
      vec_t va, vb, vt;
      rsp_t e;
      bus.cmd_valid_i = 1'b0;
      bus.cmd_write_i = 1'b0;
      bus.cmd_addr_i  = 16'd0;
      bus.cmd_wdata_i = 32'd0;
      bus.cmd_strb_i  = 4'd0;
      bus.prdata_i    = 32'd0;
      bus.pready_i    = 1'b0;
      bus.pslverr_i   = 1'b0;
      bus.busy_i      = 1'b0;

      //         write  addr      wdata         strb  waits prdata        err   exp_rdata     exp_err
      vecs[0] = '{1'b1, 16'h0004, 32'hDEADBEEF, 4'hF, 0,    32'h5555AAAA, 1'b0, 32'h00000000, 1'b0};
      vecs[1] = '{1'b0, 16'h0010, 32'hCAFEF00D, 4'hF, 3,    32'h12345678, 1'b0, 32'h12345678, 1'b0};
      vecs[2] = '{1'b1, 16'h0020, 32'h11223344, 4'h3, 1,    32'h77777777, 1'b1, 32'h00000000, 1'b1};
      vecs[3] = '{1'b0, 16'h0024, 32'h00000000, 4'h0, 0,    32'hA5A55A5A, 1'b0, 32'hA5A55A5A, 1'b0};
      vecs[4] = '{1'b0, 16'h0030, 32'h00000000, 4'h0, 2,    32'hFFFF0000, 1'b1, 32'hFFFF0000, 1'b1};
      vecs[5] = '{1'b1, 16'hFFFC, 32'h00000001, 4'h8, 5,    32'h13579BDF, 1'b0, 32'h00000000, 1'b0};

      repeat (3) @(negedge clk);
      check("reset_ready", {31'd0, bus.cmd_ready_o}, 32'd1);
      check("reset_bus", {30'd0, bus.psel_o, bus.penable_o}, 32'd0);
      check("reset_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
      check("reset_rsp_rdata", bus.rsp_rdata_o, 32'd0);
      check("reset_paddr", {16'd0, bus.paddr_o}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int k = 0; k < 6; k++) begin
         bus.busy_i = k[0];
         e = '{vecs[k].exp_rdata, vecs[k].exp_slverr, 1'b0};
         present(vecs[k], e);
         wait_accept(n);
         xfer_body(vecs[k]);
         @(negedge clk);
         check("rsp_one_cycle", {31'd0, bus.rsp_valid_o}, 32'd0);
         check("rsp_rdata_hold", bus.rsp_rdata_o, vecs[k].exp_rdata);
         check("rsp_slverr_hold", {31'd0, bus.rsp_slverr_o}, {31'd0, vecs[k].exp_slverr});
         check("idle_gap", {31'd0, bus.psel_o}, 32'd0);
      end

      // back-to-back with cmd_valid held: B waits through A and is taken on A's response cycle
      va = '{1'b1, 16'h0100, 32'hA0A0A0A0, 4'hC, 0, 32'h0, 1'b0, 32'h0, 1'b0};
      vb = '{1'b0, 16'h0104, 32'hFFFFFFFF, 4'hF, 0, 32'h0F0F1234, 1'b0, 32'h0F0F1234, 1'b0};
      present(va, '{32'h0, 1'b0, 1'b0});
      wait_accept(n);
      present(vb, '{32'h0F0F1234, 1'b0, 1'b0});
      xfer_body(va);
      wait_accept(n);
      check("b2b_accept_delay", n, 32'd0);
      xfer_body(vb);
      @(negedge clk);

      // ACCESS stretched by a slave that never answers
      vt = '{1'b0, 16'h0200, 32'h0, 4'h0, 20, 32'h2468ACE0, 1'b0, 32'h2468ACE0, 1'b0};
`ifdef APB_MASTER_TIMEOUT_EN
      present(vt, '{32'h0, 1'b1, 1'b1});
      wait_accept(n);
      @(negedge clk);
      check("to_setup_psel", {31'd0, bus.psel_o}, 32'd1);
      bus.pready_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("to_access_sel_en", {30'd0, bus.psel_o, bus.penable_o}, 32'd3);
      end
      @(negedge clk);
      check("to_abort_bus", {30'd0, bus.psel_o, bus.penable_o}, 32'd0);
      check("to_abort_pulse", {31'd0, bus.rsp_valid_o}, 32'd1);
      @(negedge clk);
`else
      present(vt, '{vt.exp_rdata, 1'b0, 1'b0});
      wait_accept(n);
      xfer_body(vt);
      @(negedge clk);
`endif

      // reset in the middle of ACCESS: bus drops at once, no response
      vt = '{1'b1, 16'h0300, 32'h55AA55AA, 4'hF, 0, 32'h0, 1'b0, 32'h0, 1'b0};
      present(vt, '{32'h0, 1'b0, 1'b0});
      wait_accept(n);
      bus.pready_i = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_reset_sel_en", {30'd0, bus.psel_o, bus.penable_o}, 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_bus", {30'd0, bus.psel_o, bus.penable_o}, 32'd0);
      sb_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("post_reset_ready", {31'd0, bus.cmd_ready_o}, 32'd1);
         check("post_reset_no_rsp", {31'd0, bus.rsp_valid_o}, 32'd0);
         check("post_reset_bus", {30'd0, bus.psel_o, bus.penable_o}, 32'd0);
      end

      check("scoreboard_drained", sb_q.size(), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
